// File: rtl/mem_port_sched_pkg.sv
// Shared types and default sizes for the memory-port scheduler.
// The _DEF suffix keeps the defaults distinct from the module parameters.
package mem_port_sched_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int LINE_BITS_DEF = 128;
    localparam int TIMEOUT_DEF   = 64;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } owner_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_e;

endpackage

// File: rtl/mem_port_sched_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that did not own the
// port last wins.
module rr_pick2
    import mem_port_sched_pkg::*;
(
    input  logic   ireq_valid,
    input  logic   dreq_valid,
    input  owner_e last_owner,
    output logic   pick_valid,
    output owner_e pick_owner
);

    always_comb begin
        pick_valid = ireq_valid | dreq_valid;
        pick_owner = OWNER_D;
        if (ireq_valid && dreq_valid) begin
            pick_owner = (last_owner == OWNER_I) ? OWNER_D : OWNER_I;
        end else if (ireq_valid) begin
            pick_owner = OWNER_I;
        end
    end

endmodule

// File: rtl/mem_port_sched.sv
// Shares the single memory port between icache and dcache: round-robin
// grant, one outstanding transaction, response routing and a timeout.
module mem_port_sched
    import mem_port_sched_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ireq_valid,
    input  logic [XLEN-1:0]      ireq_addr,
    input  logic                 dreq_valid,
    input  logic                 dreq_write,
    input  logic [XLEN-1:0]      dreq_addr,
    input  logic [LINE_BITS-1:0] dreq_wdata,
    output logic                 igrant,
    output logic                 dgrant,
    output logic                 mem_valid,
    output logic                 mem_write,
    output logic [XLEN-1:0]      mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic                 mem_rvalid,
    input  logic [LINE_BITS-1:0] mem_rdata,
    output logic                 iresp_valid,
    output logic                 dresp_valid,
    output logic [LINE_BITS-1:0] resp_rdata,
    output logic                 timeout_err,
    output sched_state_e         dbg_state
);

    // Handshakes: a request transfers in the cycle its valid is high and the
    // matching grant is high (grant is combinational from IDLE + pick); the
    // memory request transfers when mem_valid && mem_ready, and mem_valid and
    // its fields stay stable until then. mem_rvalid is only honoured in WAIT.

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    sched_state_e  state;
    owner_e        owner;
    owner_e        last_owner;
    logic [CW-1:0] cnt;
    logic          pick_valid;
    owner_e        pick_owner;
    logic          take;

    rr_pick2 u_pick (
        .ireq_valid (ireq_valid),
        .dreq_valid (dreq_valid),
        .last_owner (last_owner),
        .pick_valid (pick_valid),
        .pick_owner (pick_owner)
    );

    // Gated by reset so no grant can leak out while the block is held in reset.
    assign take      = reset && (state == IDLE) && pick_valid;
    assign igrant    = take && (pick_owner == OWNER_I);
    assign dgrant    = take && (pick_owner == OWNER_D);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= OWNER_D;
            last_owner  <= OWNER_D;
            cnt         <= '0;
            mem_valid   <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            iresp_valid <= 1'b0;
            dresp_valid <= 1'b0;
            resp_rdata  <= '0;
            timeout_err <= 1'b0;
        end else begin
            iresp_valid <= 1'b0;
            dresp_valid <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_owner;
                        mem_valid <= 1'b1;
                        state     <= ISSUE;
                        if (pick_owner == OWNER_I) begin
                            mem_write <= 1'b0;
                            mem_addr  <= ireq_addr;
                            mem_wdata <= '0;
                        end else begin
                            mem_write <= dreq_write;
                            mem_addr  <= dreq_addr;
                            mem_wdata <= dreq_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid  <= 1'b0;
                        cnt        <= '0;
                        last_owner <= owner;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving on the last allowed cycle beats the abort.
                    if (mem_rvalid) begin
                        resp_rdata  <= mem_rdata;
                        iresp_valid <= (owner == OWNER_I);
                        dresp_valid <= (owner == OWNER_D);
                        state       <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_sched.sv
// Self-checking bench for mem_port_sched: directed scenarios plus random
// transactions predicted from a transaction-level timing model.
module tb_mem_port_sched;
    import mem_port_sched_pkg::*;

    localparam int XLEN = 32;
    localparam int LB   = 128;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ireq_valid = 1'b0;
    logic [XLEN-1:0] ireq_addr = '0;
    logic            dreq_valid = 1'b0;
    logic            dreq_write = 1'b0;
    logic [XLEN-1:0] dreq_addr = '0;
    logic [LB-1:0]   dreq_wdata = '0;
    logic            igrant, dgrant;
    logic            mem_valid, mem_write;
    logic [XLEN-1:0] mem_addr;
    logic [LB-1:0]   mem_wdata;
    logic            mem_ready = 1'b0;
    logic            mem_rvalid = 1'b0;
    logic [LB-1:0]   mem_rdata = '0;
    logic            iresp_valid, dresp_valid;
    logic [LB-1:0]   resp_rdata;
    logic            timeout_err;
    sched_state_e    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    bit m_last_i = 1'b0;   // model: 1 when icache owned the last accepted transaction

    mem_port_sched #(.XLEN(XLEN), .LINE_BITS(LB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst_n),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write),
        .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
        .igrant(igrant), .dgrant(dgrant),
        .mem_valid(mem_valid), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .iresp_valid(iresp_valid), .dresp_valid(dresp_valid),
        .resp_rdata(resp_rdata), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [LB-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_quiet();
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
        dreq_write = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_quiet();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_last_i = 1'b0;
    endtask

    // One transaction, checked cycle by cycle. k counts cycles from the grant
    // cycle (k=0). With the request accepted at k=acc, a response driven at
    // acc+lat appears at acc+lat+1; with no response the abort pulse appears at
    // acc+TO+1 (TO WAIT cycles, then the pulse cycle).
    task automatic do_txn(input bit iv, input bit dv,
                          input logic [XLEN-1:0] ia, input logic [XLEN-1:0] da,
                          input bit dw, input logic [LB-1:0] dwd,
                          input int rdly, input int lat, input logic [LB-1:0] rd,
                          input bit hold, input bit noise, input string tag);
        bit own_i, to, e_ig, e_dg, e_mv, e_ir, e_dr, e_to;
        logic [XLEN-1:0] e_addr;
        logic [LB-1:0]   e_wdata;
        bit e_write;
        int acc, end_k;
        own_i   = (iv && dv) ? !m_last_i : iv;
        e_write = own_i ? 1'b0 : dw;
        e_addr  = own_i ? ia : da;
        e_wdata = own_i ? '0 : dwd;
        acc     = 1 + rdly;
        to      = (lat > TO);
        end_k   = to ? acc + TO + 1 : acc + lat + 1;
        ireq_addr  = ia;
        dreq_addr  = da;
        dreq_write = dw;
        dreq_wdata = dwd;
        for (int k = 0; k <= end_k; k++) begin
            @(negedge clk);
            ireq_valid = (k == 0) ? iv : (hold && k < end_k && iv);
            dreq_valid = (k == 0) ? dv : (hold && k < end_k && dv);
            mem_ready  = (k == acc);
            mem_rdata  = (!to && k == acc + lat) ? rd : rand_line();
            mem_rvalid = (!to && k == acc + lat) ||
                         (noise && (k <= acc || k == end_k) && ($urandom_range(0, 1) == 1));
            #1;
            e_ig = (k == 0) && own_i;
            e_dg = (k == 0) && !own_i;
            e_mv = (k >= 1) && (k <= acc);
            e_ir = !to && (k == end_k) && own_i;
            e_dr = !to && (k == end_k) && !own_i;
            e_to = to && (k == end_k);
            n_checks++;
            if ({igrant, dgrant} !== {e_ig, e_dg}) begin
                n_errors++;
                $display("FAIL %s k=%0d grant i/d got %b%b exp %b%b", tag, k, igrant, dgrant, e_ig, e_dg);
            end
            n_checks++;
            if (mem_valid !== e_mv) begin
                n_errors++;
                $display("FAIL %s k=%0d mem_valid got %b exp %b", tag, k, mem_valid, e_mv);
            end
            if (e_mv) begin
                n_checks++;
                if (mem_write !== e_write || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                    n_errors++;
                    $display("FAIL %s k=%0d mem_req got w=%b a=%h d=%h exp w=%b a=%h d=%h",
                             tag, k, mem_write, mem_addr, mem_wdata, e_write, e_addr, e_wdata);
                end
            end
            n_checks++;
            if ({iresp_valid, dresp_valid, timeout_err} !== {e_ir, e_dr, e_to}) begin
                n_errors++;
                $display("FAIL %s k=%0d resp i/d/err got %b%b%b exp %b%b%b", tag, k,
                         iresp_valid, dresp_valid, timeout_err, e_ir, e_dr, e_to);
            end
            if (e_ir || e_dr) begin
                n_checks++;
                if (resp_rdata !== rd) begin
                    n_errors++;
                    $display("FAIL %s k=%0d resp_rdata got %h exp %h", tag, k, resp_rdata, rd);
                end
            end
            if (k == end_k) begin
                n_checks++;
                if (dbg_state !== (to ? IDLE : RESP)) begin
                    n_errors++;
                    $display("FAIL %s k=%0d state got %0d exp %0d", tag, k, dbg_state, to ? IDLE : RESP);
                end
            end
        end
        m_last_i = own_i;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_quiet();
        ireq_valid = 1'b1;
        dreq_valid = 1'b1;
        #1;
        n_checks++;
        if ({igrant, dgrant, mem_valid, mem_write, iresp_valid, dresp_valid, timeout_err} !== 7'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || resp_rdata !== '0 || dbg_state !== IDLE) begin
            n_errors++;
            $display("FAIL reset outputs got g=%b%b mv=%b mw=%b r=%b%b e=%b a=%h st=%0d exp all zero/IDLE",
                     igrant, dgrant, mem_valid, mem_write, iresp_valid, dresp_valid,
                     timeout_err, mem_addr, dbg_state);
        end
        apply_reset();
    endtask

    task automatic test_icache_only();
        apply_reset();
        do_txn(1, 0, 32'h100, 32'h0, 0, '0, 0, 3, {16{8'hA5}}, 0, 0, "icache_only");
    endtask

    task automatic test_tie_alternation();
        apply_reset();
        for (int n = 0; n < 4; n++)
            do_txn(1, 1, 32'h1000 + n * 16, 32'h3000 + n * 16, 0, '0,
                   $urandom_range(0, 2), $urandom_range(1, 4), rand_line(), 1, 0, "tie");
    endtask

    task automatic test_dcache_writeback();
        do_txn(0, 1, 32'h0, 32'h2000, 1, {4{32'hDEADBEEF}}, 4, 2, rand_line(), 0, 1, "dcache_wb");
    endtask

    task automatic test_timeout();
        do_txn(1, 0, 32'h440, 32'h0, 0, '0, 1, TO + 1, rand_line(), 0, 0, "timeout");
        do_txn(0, 1, 32'h0, 32'h880, 0, rand_line(), 0, 2, rand_line(), 0, 0, "after_timeout");
    endtask

    task automatic test_resp_at_limit();
        do_txn(1, 1, 32'h500, 32'h600, 0, '0, 0, TO, rand_line(), 0, 0, "resp_at_limit");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        ireq_valid = 1'b1;
        ireq_addr  = 32'h7700;
        #1;
        n_checks++;
        if (igrant !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid grant got %b exp 1", igrant);
        end
        @(negedge clk);
        ireq_valid = 1'b0;
        mem_ready  = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        ireq_valid = 1'b1;
        dreq_valid = 1'b1;
        #1;
        n_checks++;
        if ({igrant, dgrant, mem_valid, iresp_valid, dresp_valid, timeout_err} !== 6'b0 ||
            mem_addr !== '0 || resp_rdata !== '0) begin
            n_errors++;
            $display("FAIL reset_mid outputs got g=%b%b mv=%b r=%b%b e=%b a=%h exp zero",
                     igrant, dgrant, mem_valid, iresp_valid, dresp_valid, timeout_err, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_last_i = 1'b0;
        drive_quiet();
        mem_rvalid = 1'b1;
        mem_rdata  = rand_line();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            #1;
            n_checks++;
            if ({iresp_valid, dresp_valid, timeout_err} !== 3'b0) begin
                n_errors++;
                $display("FAIL reset_mid late_rvalid k=%0d got %b%b%b exp 000",
                         k, iresp_valid, dresp_valid, timeout_err);
            end
        end
        do_txn(1, 1, 32'h10, 32'h20, 1, rand_line(), 0, 1, rand_line(), 0, 0, "tie_after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int pat;
            pat = $urandom_range(1, 3);
            do_txn(pat[0], pat[1], $urandom, $urandom, $urandom_range(0, 1) == 1, rand_line(),
                   $urandom_range(0, 3), $urandom_range(1, TO + 2), rand_line(),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_icache_only();
        test_tie_alternation();
        test_dcache_writeback();
        test_timeout();
        test_resp_at_limit();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
